scarv_cop_mem_responder: RTL and testbench

Synthesisable memory responder that terminates the coprocessor's `cop_mem_*` bus. The COP is the initiator; this block is the responder. It provides a word-addressed SRAM with byte-enabled writes, pseudo-random stall injection and out-of-range error signalling. It replaces the random memory stimulus in COP-level benches, and it serves as the scratch memory in FPGA and system integrations.

---
 rtl/scarv_cop_mem_responder.sv | 138 +++++++++++++
 tb/tb_scarv_cop_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_mem_responder.sv
// Purpose : word-addressed SRAM responder terminating the COP cop_mem_* bus, with
//           byte-enabled writes, LFSR-driven stall injection and out-of-range errors.
// Latency : a request is accepted on the first edge where stall=0; rdata/error are
//           valid in the cycle after the accept edge (one request per cycle when no stalls).
// Backpressure: cop_mem_stall holds the initiator for 0..STALL_MAX cycles per request;
//           the initiator must keep wen/addr/wdata/ben stable while stalled.
// Ports   : g_clk, g_resetn (async active-low) ; stall_en enables random stalls ;
//           cop_mem_cen/wen/addr/wdata/ben form the request ;
//           cop_mem_rdata/error are registered responses, cop_mem_stall is combinational.
module scarv_cop_mem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned STALL_MAX = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        stall_en,
   input  logic        cop_mem_cen,
   input  logic        cop_mem_wen,
   input  logic [31:0] cop_mem_addr,
   input  logic [31:0] cop_mem_wdata,
   input  logic [3:0]  cop_mem_ben,
   output logic [31:0] cop_mem_rdata,
   output logic        cop_mem_stall,
   output logic        cop_mem_error
);

   localparam int         AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [3:0] STALL_MAX_C = 4'(STALL_MAX);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [15:0] r_lfsr;
   logic [31:0] r_rdata;
   logic        r_error;
   logic [31:0] r_mem [MEM_WORDS];

   logic [15:0] w_lfsr_nxt;
   logic [3:0]  w_n;
   logic        w_stall;
   logic        w_accept;
   logic [29:0] w_word_off;
   logic        w_in_range;
   logic [AW-1:0] w_idx;
   logic        w_wr;
   logic        w_unused;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   assign w_lfsr_nxt = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400)
                                 : {1'b0, r_lfsr[15:1]};

   // Stall draw for a request that arrives while IDLE.
   assign w_n = !stall_en                   ? 4'd0 :
                (r_lfsr[3:0] > STALL_MAX_C) ? STALL_MAX_C : r_lfsr[3:0];

   // Only cen and registered state feed the stall; address/data never do.
   assign w_stall = cop_mem_cen & (((r_state == ST_IDLE) & (w_n != 4'd0)) |
                                   ((r_state == ST_BUSY) & (r_cnt != 4'd0)));

   assign cop_mem_stall = g_resetn & w_stall;
   assign w_accept      = g_resetn & cop_mem_cen & ~w_stall;

   // Decode on word granularity; the byte-lane bits play no part.
   assign w_word_off = cop_mem_addr[31:2] - BASE_ADDR[31:2];
   assign w_in_range = (cop_mem_addr[31:2] >= BASE_ADDR[31:2]) &&
                       ({2'b00, w_word_off} < MEM_WORDS);
   assign w_idx      = w_word_off[AW-1:0];
   assign w_wr       = w_accept & cop_mem_wen & w_in_range;
   assign w_unused   = ^cop_mem_addr[1:0];

   // Control, LFSR and response registers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_lfsr  <= LFSR_SEED;
         r_rdata <= 32'd0;
         r_error <= 1'b0;
      end else begin
         r_lfsr  <= w_lfsr_nxt;
         r_error <= 1'b0;

         if (w_accept) begin
            if (!w_in_range) begin
               r_rdata <= 32'd0;
               r_error <= 1'b1;
            end else if (!cop_mem_wen) begin
               r_rdata <= r_mem[w_idx];
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (cop_mem_cen && (w_n != 4'd0)) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= w_n - 4'd1;
               end
            end
            ST_BUSY: begin
               if (!cop_mem_cen) begin
                  // Initiator withdrew: abandon the request without side effects.
                  r_state <= ST_IDLE;
                  r_cnt   <= 4'd0;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Storage array: no reset so it can map onto block RAM.
   always_ff @(posedge g_clk) begin
      if (w_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (cop_mem_ben[i]) begin
               r_mem[w_idx][8*i +: 8] <= cop_mem_wdata[8*i +: 8];
            end
         end
      end
   end

   assign cop_mem_rdata = r_rdata;
   assign cop_mem_error = r_error;

endmodule

// File: tb/tb_scarv_cop_mem_responder.sv
// Purpose : self-checking bench for scarv_cop_mem_responder with a per-cycle model.
// Latency : model predicts stall in-cycle and rdata/error one cycle after accept.
// Backpressure: request task holds the request stable until stall drops.
module tb_scarv_cop_mem_responder;

   localparam int          SMAX = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        stall_en;
   logic        cen;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  ben;
   logic [31:0] rdata;
   logic        stall;
   logic        error;

   int checks = 0;
   int errors = 0;

   scarv_cop_mem_responder #(
      .MEM_WORDS (1024),
      .BASE_ADDR (32'h0000_0000),
      .STALL_MAX (SMAX),
      .LFSR_SEED (SEED)
   ) dut (
      .g_clk         (g_clk),
      .g_resetn      (g_resetn),
      .stall_en      (stall_en),
      .cop_mem_cen   (cen),
      .cop_mem_wen   (wen),
      .cop_mem_addr  (addr),
      .cop_mem_wdata (wdata),
      .cop_mem_ben   (ben),
      .cop_mem_rdata (rdata),
      .cop_mem_stall (stall),
      .cop_mem_error (error)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // ---------------- behavioural model ----------------
   logic [15:0] m_lfsr;
   logic [31:0] m_mem [0:1023];
   logic [3:0]  m_kn  [0:1023];
   bit          m_in_req;
   int          m_age;
   int          m_n;
   logic [31:0] exp_rdata;
   bit          exp_rd_vld;
   logic        exp_error;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         m_kn[i]  = 4'h0;
         m_mem[i] = 32'd0;
      end
      m_lfsr     = SEED;
      m_in_req   = 0;
      exp_rdata  = 32'd0;
      exp_rd_vld = 1;
      exp_error  = 1'b0;
   end

   // Inputs change only just after posedge, so at negedge they are the values the
   // next posedge will act on.
   always @(negedge g_clk) begin : model
      bit acc;
      bit exp_stall;
      int word;
      if (!g_resetn) begin
         chk("rst_stall", {31'd0, stall}, 32'd0);
         chk("rst_rdata", rdata, 32'd0);
         chk("rst_error", {31'd0, error}, 32'd0);
         m_lfsr     = SEED;
         m_in_req   = 0;
         exp_rdata  = 32'd0;
         exp_rd_vld = 1;
         exp_error  = 1'b0;
      end else begin
         chk("m_error", {31'd0, error}, {31'd0, exp_error});
         if (exp_rd_vld) chk("m_rdata", rdata, exp_rdata);
         acc       = 0;
         exp_stall = 0;
         if (cen) begin
            if (!m_in_req) begin
               m_in_req = 1;
               m_age    = 0;
               m_n      = !stall_en ? 0 : ((int'(m_lfsr[3:0]) > SMAX) ? SMAX : int'(m_lfsr[3:0]));
            end
            exp_stall = (m_age < m_n);
            if (exp_stall) m_age++;
            else begin
               acc      = 1;
               m_in_req = 0;
            end
         end else begin
            m_in_req = 0;
         end
         chk("m_stall", {31'd0, stall}, {31'd0, exp_stall});
         exp_error = 1'b0;
         if (acc) begin
            if (addr >= 32'h0000_1000) begin
               exp_error  = 1'b1;
               exp_rdata  = 32'd0;
               exp_rd_vld = 1;
            end else begin
               word = int'(addr[11:2]);
               if (wen) begin
                  for (int l = 0; l < 4; l++) begin
                     if (ben[l]) begin
                        m_mem[word][8*l +: 8] = wdata[8*l +: 8];
                        m_kn[word][l]         = 1'b1;
                     end
                  end
               end else begin
                  exp_rdata  = m_mem[word];
                  exp_rd_vld = (m_kn[word] == 4'hF);
               end
            end
         end
         m_lfsr = lfsr_step(m_lfsr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   // Present one request (caller is just after a posedge), hold it while stalled,
   // and return just after the accept edge with cen low.
   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int waits);
      waits = 0;
      cen = 1'b1; wen = w; addr = a; wdata = d; ben = b;
      forever begin
         @(negedge g_clk);
         if (!stall) break;
         waits++;
         if (waits > 20) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=%0d waits required<=%0d", waits, SMAX);
            break;
         end
      end
      step();
      cen = 1'b0;
   endtask

   // Idle until the model says the next request will draw a non-zero stall.
   task automatic wait_stall_draw();
      int k = 0;
      while (m_lfsr[3:0] == 4'd0 && k < 50) begin
         step();
         k++;
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int wt;
      int wt2;
      int r;
      logic [31:0] a;
      g_resetn = 1'b0; stall_en = 1'b0; cen = 1'b0; wen = 1'b0;
      addr = 32'd0; wdata = 32'd0; ben = 4'h0;
      repeat (3) @(posedge g_clk);
      #1;
      g_resetn = 1'b1;

      // Preload words 0..15 back to back.
      for (int i = 0; i < 16; i++) req(1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF, wt);

      // Write then read, no stalls.
      req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, wt);
      chk("wr_nostall", 32'(wt), 32'd0);
      req(1'b0, 32'h10, 32'd0, 4'h0, wt);
      chk("rd_nostall", 32'(wt), 32'd0);
      @(negedge g_clk);
      chk("wr_rd_data", rdata, 32'hDEAD_BEEF);
      chk("wr_rd_err", {31'd0, error}, 32'd0);
      step();

      // Partial byte write.
      req(1'b1, 32'h20, 32'h1122_3344, 4'hF, wt);
      req(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, wt);
      req(1'b0, 32'h20, 32'd0, 4'h0, wt);
      @(negedge g_clk);
      chk("partial", rdata, 32'h11BB_33DD);
      step();

      // Out of range read, then write.
      req(1'b0, 32'h1000, 32'd0, 4'hF, wt);
      @(negedge g_clk);
      chk("oor_rd_err", {31'd0, error}, 32'd1);
      chk("oor_rd_data", rdata, 32'd0);
      step();
      @(negedge g_clk);
      chk("oor_rd_pulse", {31'd0, error}, 32'd0);
      step();
      req(1'b1, 32'h1000, 32'h5555_5555, 4'hF, wt);
      @(negedge g_clk);
      chk("oor_wr_err", {31'd0, error}, 32'd1);
      step();
      @(negedge g_clk);
      chk("oor_wr_pulse", {31'd0, error}, 32'd0);
      step();
      req(1'b0, 32'h0, 32'd0, 4'h0, wt);
      @(negedge g_clk);
      chk("oor_word0", rdata, 32'hA5A5_0000);
      step();

      // Back-to-back reads of words 0, 1, 2.
      cen = 1'b1; wen = 1'b0; addr = 32'h0;
      step(); addr = 32'h4;
      @(negedge g_clk); chk("b2b_0", rdata, 32'hA5A5_0000);
      step(); addr = 32'h8;
      @(negedge g_clk); chk("b2b_1", rdata, 32'hA5A5_0001);
      step(); cen = 1'b0;
      @(negedge g_clk); chk("b2b_2", rdata, 32'hA5A5_0002);
      step();

      // Withdrawal while stalled on a write to 0x30.
      stall_en = 1'b1;
      wait_stall_draw();
      cen = 1'b1; wen = 1'b1; addr = 32'h30; wdata = 32'h0BAD_0BAD; ben = 4'hF;
      @(negedge g_clk);
      chk("wd_stalled", {31'd0, stall}, 32'd1);
      step();
      cen = 1'b0;
      req(1'b0, 32'h30, 32'd0, 4'h0, wt);
      @(negedge g_clk);
      chk("wd_old_data", rdata, 32'hA5A5_000C);
      step();

      // Reset while BUSY on a write to 0x34.
      wait_stall_draw();
      cen = 1'b1; wen = 1'b1; addr = 32'h34; wdata = 32'h0BAD_0BAD; ben = 4'hF;
      @(negedge g_clk);
      chk("rs_stalled", {31'd0, stall}, 32'd1);
      #1 g_resetn = 1'b0;
      #1;
      chk("rs_stall0", {31'd0, stall}, 32'd0);
      chk("rs_rdata0", rdata, 32'd0);
      chk("rs_error0", {31'd0, error}, 32'd0);
      cen = 1'b0;
      @(posedge g_clk);
      @(posedge g_clk);
      #1;
      g_resetn = 1'b1;
      // Fresh LFSR: draws 1 (seed nibble 1), then 3 two cycles later.
      req(1'b0, 32'h30, 32'd0, 4'h0, wt);
      req(1'b0, 32'h34, 32'd0, 4'h0, wt2);
      chk("rs_first_wait", 32'(wt), 32'd1);
      chk("rs_second_wait", 32'(wt2), 32'd3);
      @(negedge g_clk);
      chk("rs_no_write", rdata, 32'hA5A5_000D);
      step();

      // Random traffic with stalls.
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) step();
         r = $urandom_range(0, 19);
         if (r < 16) a = 32'(r * 4) | 32'($urandom_range(0, 3));
         else if (r < 19) a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         else a = 32'hFFFF_FFFC;
         req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), wt);
         checks++;
         if (wt > SMAX) begin
            errors++;
            $display("FAIL stall_count actual=%0d required<=%0d", wt, SMAX);
         end
      end
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
